// File: rtl/sa_result_collector.sv
// Deskews systolic-array column results, buffers aligned vectors in a FIFO
// and frames one convolution pass with start/count and a done pulse.
module sa_result_collector #(
    parameter int N_COLS_ARRAY = 4,
    parameter int I_WIDTH      = 8,
    parameter int F_WIDTH      = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic signed [F_WIDTH+I_WIDTH-1:0]         result_i [0:N_COLS_ARRAY-1],
    input  logic                                      col_valid_i [0:N_COLS_ARRAY-1],
    input  logic                                      start_i,
    input  logic [CNT_WIDTH-1:0]                      num_out_i,
    output logic [N_COLS_ARRAY*(F_WIDTH+I_WIDTH)-1:0] out_data_o,
    output logic                                      out_valid_o,
    input  logic                                      out_ready_i,
    output logic                                      busy_o,
    output logic                                      done_o,
    output logic                                      overflow_o,
    output logic                                      skew_err_o
);

    localparam int RW = F_WIDTH + I_WIDTH;
    localparam int VW = N_COLS_ARRAY * RW;
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
    localparam logic [AW:0]          PTR_ONE = 1;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN,
        FINISH
    } state_t;

    logic [RW-1:0]           al_data [0:N_COLS_ARRAY-1];
    logic [N_COLS_ARRAY-1:0] al_valid;
    logic [VW-1:0]           vec;

    // Column c is delayed N_COLS_ARRAY-1-c cycles so all lanes meet.
    for (genvar c = 0; c < N_COLS_ARRAY; c++) begin : g_col
        localparam int D = N_COLS_ARRAY - 1 - c;
        if (D == 0) begin : g_pass
            assign al_data[c]  = result_i[c];
            assign al_valid[c] = col_valid_i[c];
        end else begin : g_dly
            logic [RW-1:0] d_q [0:D-1];
            logic          v_q [0:D-1];

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    for (int k = 0; k < D; k++) begin
                        d_q[k] <= '0;
                        v_q[k] <= 1'b0;
                    end
                end else begin
                    d_q[0] <= result_i[c];
                    v_q[0] <= col_valid_i[c];
                    for (int k = 1; k < D; k++) begin
                        d_q[k] <= d_q[k-1];
                        v_q[k] <= v_q[k-1];
                    end
                end
            end

            assign al_data[c]  = d_q[D-1];
            assign al_valid[c] = v_q[D-1];
        end
    end

    always_comb begin
        vec = '0;
        for (int c = 0; c < N_COLS_ARRAY; c++) begin
            vec[c*RW +: RW] = al_data[c];
        end
    end

    state_t               state_q;
    logic [CNT_WIDTH-1:0] num_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_inc;

    logic [VW-1:0] mem [0:FIFO_DEPTH-1];
    logic [AW:0]   wptr_q;
    logic [AW:0]   rptr_q;

    logic all_v;
    logic part_v;
    logic empty;
    logic full;
    logic push_req;
    logic push;
    logic pop;
    logic drop;

    assign all_v    = &al_valid;
    assign part_v   = (|al_valid) && !all_v;
    assign empty    = (wptr_q == rptr_q);
    assign full     = (wptr_q[AW] != rptr_q[AW]) &&
                      (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop      = !empty && out_ready_i;
    assign push_req = (state_q == COLLECT) && all_v;
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;
    assign cnt_inc  = cnt_q + CNT_ONE;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wptr_q[AW-1:0]] <= vec;
                wptr_q              <= wptr_q + PTR_ONE;
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_ONE;
            end
        end
    end

    assign out_valid_o = !empty;
    assign out_data_o  = empty ? '0 : mem[rptr_q[AW-1:0]];

    // DRAIN sees the empty FIFO the cycle after the last pop P, so done is at P+2.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            num_q      <= '0;
            cnt_q      <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            overflow_o <= 1'b0;
            skew_err_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        num_q      <= num_out_i;
                        cnt_q      <= '0;
                        overflow_o <= 1'b0;
                        skew_err_o <= 1'b0;
                        if (num_out_i == '0) begin
                            state_q <= FINISH;
                            done_o  <= 1'b1;
                        end else begin
                            state_q <= COLLECT;
                            busy_o  <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (drop) begin
                        overflow_o <= 1'b1;
                    end
                    if (part_v) begin
                        skew_err_o <= 1'b1;
                    end
                    if (all_v) begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == num_q) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (empty) begin
                        state_q <= FINISH;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sa_result_collector.sv
// Directed bench for sa_result_collector: deskew, FIFO, framing, flags.
module tb_sa_result_collector;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [15:0] result [0:3];
    logic               col_valid [0:3];
    logic               start = 1'b0;
    logic [15:0]        num = '0;
    logic [63:0]        out_data;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic               busy;
    logic               done;
    logic               overflow;
    logic               skew_err;

    logic signed [15:0] vecs [0:7][0:3];
    int                 n_cmp = 0;
    int                 n_err = 0;
    logic               got;

    sa_result_collector dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .result_i    (result),
        .col_valid_i (col_valid),
        .start_i     (start),
        .num_out_i   (num),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .busy_o      (busy),
        .done_o      (done),
        .overflow_o  (overflow),
        .skew_err_o  (skew_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack(input int i);
        return {vecs[i][3], vecs[i][2], vecs[i][1], vecs[i][0]};
    endfunction

    task automatic drive_slot(input int t, input int nvec,
                              input int mv, input int mc);
        for (int c = 0; c < 4; c++) begin
            int idx;
            idx = t - c;
            if (idx >= 0 && idx < nvec && !(idx == mv && c == mc)) begin
                col_valid[c] = 1'b1;
                result[c]    = vecs[idx][c];
            end else begin
                col_valid[c] = 1'b0;
                result[c]    = '0;
            end
        end
    endtask

    task automatic clear_cols();
        drive_slot(-1, 0, -1, -1);
    endtask

    task automatic send(input int nvec, input int mv, input int mc);
        for (int t = 0; t < nvec + 3; t++) begin
            drive_slot(t, nvec, mv, mc);
            step();
        end
        clear_cols();
    endtask

    task automatic do_start(input logic [15:0] n);
        start = 1'b1;
        num   = n;
        step();
        start = 1'b0;
    endtask

    initial begin
        clear_cols();

        // reset values
        step();
        step();
        chk1("rst_valid", out_valid, 1'b0);
        chk64("rst_data", out_data, 64'h0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_ovf", overflow, 1'b0);
        chk1("rst_skew", skew_err, 1'b0);
        rst_n = 1'b1;
        step();

        // single vector alignment
        vecs[0][0] = 16'sd5;
        vecs[0][1] = -16'sd3;
        vecs[0][2] = 16'sd7;
        vecs[0][3] = 16'sd32767;
        do_start(16'd1);
        chk1("t2_busy", busy, 1'b1);
        for (int t = 0; t < 4; t++) begin
            drive_slot(t, 1, -1, -1);
            chk1("t2_early_valid", out_valid, 1'b0);
            step();
        end
        clear_cols();
        chk1("t2_valid", out_valid, 1'b1);
        chk64("t2_data", out_data, 64'h7FFF_0007_FFFD_0005);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk1("t2_popped", out_valid, 1'b0);
        chk1("t2_busy_drain", busy, 1'b1);
        chk1("t2_done_early", done, 1'b0);
        step();
        chk1("t2_done", done, 1'b1);
        chk1("t2_busy_fall", busy, 1'b0);
        step();
        chk1("t2_done_pulse", done, 1'b0);

        // backpressure overflow
        for (int i = 0; i < 6; i++)
            for (int c = 0; c < 4; c++)
                vecs[i][c] = 16'(i * 16 + c + 1);
        do_start(16'd6);
        for (int t = 0; t < 9; t++) begin
            drive_slot(t, 6, -1, -1);
            if (t == 7) chk1("t3_ovf_before", overflow, 1'b0);
            if (t == 8) chk1("t3_ovf_5th", overflow, 1'b1);
            step();
        end
        clear_cols();
        chk1("t3_busy", busy, 1'b1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk1("t3_valid", out_valid, 1'b1);
            chk64("t3_data", out_data, pack(k));
            step();
        end
        chk1("t3_empty", out_valid, 1'b0);
        chk1("t3_done_early", done, 1'b0);
        step();
        chk1("t3_done", done, 1'b1);
        chk1("t3_ovf_sticky", overflow, 1'b1);
        out_ready = 1'b0;
        step();

        // full FIFO with simultaneous pop
        for (int i = 0; i < 5; i++)
            for (int c = 0; c < 4; c++)
                vecs[i][c] = 16'(-(i * 256 + c + 9));
        do_start(16'd5);
        chk1("t4_ovf_cleared", overflow, 1'b0);
        for (int t = 0; t < 8; t++) begin
            drive_slot(t, 5, -1, -1);
            out_ready = (t == 7);
            step();
        end
        clear_cols();
        out_ready = 1'b0;
        chk1("t4_no_ovf", overflow, 1'b0);
        chk64("t4_head", out_data, pack(1));
        out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            chk1("t4_valid", out_valid, 1'b1);
            chk64("t4_data", out_data, pack(k));
            step();
        end
        chk1("t4_empty", out_valid, 1'b0);
        step();
        chk1("t4_done", done, 1'b1);
        chk1("t4_no_ovf_end", overflow, 1'b0);
        out_ready = 1'b0;
        step();

        // skew error
        for (int c = 0; c < 4; c++) vecs[0][c] = 16'(c * 1000 - 1500);
        do_start(16'd1);
        send(1, 0, 2);
        chk1("t5_skew", skew_err, 1'b1);
        chk1("t5_no_push", out_valid, 1'b0);
        chk1("t5_busy", busy, 1'b1);
        step();
        chk1("t5_busy_hold", busy, 1'b1);
        chk1("t5_no_done", done, 1'b0);
        send(1, -1, -1);
        chk1("t5_valid", out_valid, 1'b1);
        chk64("t5_data", out_data, pack(0));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk1("t5_popped", out_valid, 1'b0);
        step();
        chk1("t5_done", done, 1'b1);
        chk1("t5_skew_sticky", skew_err, 1'b1);
        step();

        // zero-length frame and ignored start
        do_start(16'd0);
        chk1("t6_zero_done", done, 1'b1);
        chk1("t6_zero_busy", busy, 1'b0);
        chk1("t6_skew_cleared", skew_err, 1'b0);
        step();
        chk1("t6_zero_pulse", done, 1'b0);
        out_ready = 1'b1;
        do_start(16'd3);
        chk1("t6_busy", busy, 1'b1);
        send(1, -1, -1);
        do_start(16'd1);
        send(1, -1, -1);
        for (int i = 0; i < 3; i++) begin
            chk1("t6_not_done", done, 1'b0);
            step();
        end
        chk1("t6_still_busy", busy, 1'b1);
        send(1, -1, -1);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (done) got = 1'b1;
            else step();
        end
        chk1("t6_done_seen", got, 1'b1);
        chk1("t6_busy_off", busy, 1'b0);
        out_ready = 1'b0;
        step();

        // reset mid-stream
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < 4; c++)
                vecs[i][c] = 16'(i * 7 + c + 100);
        do_start(16'd4);
        send(2, -1, -1);
        chk1("t7_valid", out_valid, 1'b1);
        chk64("t7_data", out_data, pack(0));
        #2;
        rst_n = 1'b0;
        #1;
        chk1("t7_rst_valid", out_valid, 1'b0);
        chk64("t7_rst_data", out_data, 64'h0);
        chk1("t7_rst_busy", busy, 1'b0);
        chk1("t7_rst_done", done, 1'b0);
        chk1("t7_rst_ovf", overflow, 1'b0);
        chk1("t7_rst_skew", skew_err, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk1("t7_post_valid", out_valid, 1'b0);
            step();
        end
        chk1("t7_post_busy", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
